// File: rtl/alu_arbiter_if.sv
// Bundle of the requester, ALU and response signals around alu_arbiter.
// master = the arbiter, slave = its surroundings (requesters, ALU, consumer).
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req0_cin;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       req1_cin;
  logic [3:0] alu_in1;
  logic [3:0] alu_in0;
  logic       alu_cin;
  logic [2:0] alu_instr;
  logic [3:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_id;
  logic       busy;

  modport master (
    input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
    input  alu_result, rsp_ready,
    output req0_ready, req1_ready,
    output alu_in1, alu_in0, alu_cin, alu_instr,
    output rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    output req0_valid, req0_op, req0_a, req0_b, req0_cin,
    output req1_valid, req1_op, req1_a, req1_b, req1_cin,
    output alu_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_in1, alu_in0, alu_cin, alu_instr,
    input  rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one 4-bit ALU between two requesters.
// Holds the ALU operands across its pipeline and returns the result tagged with the owner.
module alu_arbiter #(
  parameter int ALU_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  alu_arbiter_if.master bus
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic          last_grant_r;
  logic          id_r;
  logic [3:0]    alu_in1_r;
  logic [3:0]    alu_in0_r;
  logic          alu_cin_r;
  logic [2:0]    alu_instr_r;
  logic [3:0]    rsp_data_r;
  logic          rsp_id_r;

  logic          idle_s;
  logic          grant0_s;
  logic          grant1_s;
  logic          accept_s;
  logic [2:0]    win_op_s;
  logic [3:0]    win_a_s;
  logic [3:0]    win_b_s;
  logic          win_cin_s;

  // Ready is suppressed while reset is held so no handshake is seen during reset.
  assign idle_s   = (state_r == S_IDLE) && !rst;
  assign accept_s = idle_s && (grant0_s || grant1_s);

  // Round-robin choice: a lone requester wins, a tie goes to the one not granted last.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (bus.req0_valid && (!bus.req1_valid || last_grant_r)) begin
      grant0_s = 1'b1;
    end else if (bus.req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Operation fields of the current winner.
  always_comb begin
    win_op_s  = bus.req0_op;
    win_a_s   = bus.req0_a;
    win_b_s   = bus.req0_b;
    win_cin_s = bus.req0_cin;
    if (grant1_s) begin
      win_op_s  = bus.req1_op;
      win_a_s   = bus.req1_a;
      win_b_s   = bus.req1_b;
      win_cin_s = bus.req1_cin;
    end else begin
      win_op_s  = bus.req0_op;
      win_a_s   = bus.req0_a;
      win_b_s   = bus.req0_b;
      win_cin_s = bus.req0_cin;
    end
  end

  // Sequencer: accept, wait out the ALU pipeline, capture, present until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cnt_r        <= {CW{1'b0}};
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      alu_in1_r    <= 4'd0;
      alu_in0_r    <= 4'd0;
      alu_cin_r    <= 1'b0;
      alu_instr_r  <= 3'd0;
      rsp_data_r   <= 4'd0;
      rsp_id_r     <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            alu_in1_r    <= win_a_s;
            alu_in0_r    <= win_b_s;
            alu_cin_r    <= win_cin_s;
            alu_instr_r  <= win_op_s;
            id_r         <= grant1_s;
            last_grant_r <= grant1_s;
            cnt_r        <= CW'(ALU_LAT - 1);
            state_r      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= S_CAPT;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        S_CAPT: begin
          rsp_data_r <= bus.alu_result;
          rsp_id_r   <= id_r;
          state_r    <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = idle_s && grant0_s;
  assign bus.req1_ready = idle_s && grant1_s;
  assign bus.alu_in1    = alu_in1_r;
  assign bus.alu_in0    = alu_in0_r;
  assign bus.alu_cin    = alu_cin_r;
  assign bus.alu_instr  = alu_instr_r;
  assign bus.rsp_valid  = (state_r == S_RESP);
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.busy       = (state_r != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: driver predicts grants and results, monitor checks responses.
module tb_alu_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter #(.ALU_LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       id;
    logic [3:0] data;
    int         acc;
  } exp_t;

  exp_t        sbq[$];
  int          acc_hist[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          acc_id = -1;
  logic        model_last = 1'b1;
  logic [11:0] new_alu = 12'd0;
  logic [11:0] old_alu = 12'd0;
  int          alu_acc = 0;

  logic       st_v[2];
  logic [2:0] st_op[2];
  logic [3:0] st_a[2];
  logic [3:0] st_b[2];
  logic       st_c[2];
  logic       st_rr;

  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic cin);
    logic [3:0] c4;
    c4 = {3'b000, cin};
    case (op)
      3'd1:    return a + b + c4;
      3'd2:    return a + ~b + c4;
      3'd3:    return a + (cin ? 4'h0 : 4'hF);
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return a & b;
      default: return b;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ALU model: input registers, then output register using the live opcode.
  logic [3:0] ia, ib;
  logic       ic;
  always @(posedge clk) begin
    ia             <= bus.alu_in1;
    ib             <= bus.alu_in0;
    ic             <= bus.alu_cin;
    bus.alu_result <= alu_ref(bus.alu_instr, ia, ib, ic);
    cyc            <= cyc + 1;
  end

  // Apply staged stimulus, then predict the grant and queue the expected response.
  task automatic tick();
    logic [1:0] exp_g;
    logic       w;
    exp_t       e;
    @(negedge clk);
    bus.req0_valid = st_v[0]; bus.req0_op = st_op[0]; bus.req0_a = st_a[0];
    bus.req0_b = st_b[0]; bus.req0_cin = st_c[0];
    bus.req1_valid = st_v[1]; bus.req1_op = st_op[1]; bus.req1_a = st_a[1];
    bus.req1_b = st_b[1]; bus.req1_cin = st_c[1];
    bus.rsp_ready = st_rr;
    #1;
    acc_id = -1;
    exp_g  = 2'b00;
    w      = 1'b0;
    if (sbq.size() == 0) begin
      if (st_v[0] && st_v[1]) w = ~model_last;
      else w = st_v[1];
      if (st_v[0] || st_v[1]) exp_g = 2'b01 << w;
    end
    chk("ready_grant", {bus.req1_ready, bus.req0_ready}, exp_g);
    if (exp_g != 2'b00) begin
      e.id   = w;
      e.data = alu_ref(st_op[w], st_a[w], st_b[w], st_c[w]);
      e.acc  = cyc + 1;
      sbq.push_back(e);
      model_last = w;
      acc_id     = int'(w);
      acc_hist.push_back(cyc + 1);
      old_alu = new_alu;
      new_alu = {st_op[w], st_a[w], st_b[w], st_c[w]};
      alu_acc = cyc + 1;
    end
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("reset_outputs", {bus.req0_ready, bus.req1_ready, bus.alu_in1, bus.alu_in0,
        bus.alu_cin, bus.alu_instr, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.busy}, 0);
    sbq.delete();
    acc_hist.delete();
    model_last = 1'b1;
    new_alu = 12'd0;
    old_alu = 12'd0;
    alu_acc = 0;
    st_v[0] = 1'b0;
    st_v[1] = 1'b0;
    st_rr = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input int i, input logic [2:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic c);
    int n;
    n = 0;
    st_v[i] = 1'b1; st_op[i] = op; st_a[i] = a; st_b[i] = b; st_c[i] = c;
    do begin
      tick();
      n++;
    end while (acc_id != i && n < 30);
    st_v[i] = 1'b0;
    if (acc_id != i) chk("issue_timeout", acc_id, i);
  endtask

  task automatic check_interval();
    for (int k = 1; k < acc_hist.size(); k++)
      chk("issue_interval", acc_hist[k] - acc_hist[k-1], LAT + 3);
  endtask

  // Response monitor: latency, hold under backpressure, ALU operand stability, busy.
  logic       pv_r = 1'b0;
  logic       ps_r = 1'b0;
  logic [3:0] pd_r = 4'd0;
  logic       pid_r = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      pv_r <= 1'b0;
      ps_r <= 1'b0;
    end else begin
      chk("alu_regs", {bus.alu_instr, bus.alu_in1, bus.alu_in0, bus.alu_cin},
          (cyc >= alu_acc) ? new_alu : old_alu);
      chk("busy", bus.busy, (sbq.size() > 0 && cyc >= sbq[0].acc) ? 1 : 0);
      if (ps_r) chk("rsp_hold", {bus.rsp_valid, bus.rsp_id, bus.rsp_data}, {1'b1, pid_r, pd_r});
      if (bus.rsp_valid && !pv_r) begin
        chk("rsp_expected", sbq.size(), 1);
        if (sbq.size() > 0) chk("latency", cyc - sbq[0].acc, LAT + 1);
      end
      if (bus.rsp_valid && bus.rsp_ready && sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_data", bus.rsp_data, e.data);
      end
      pv_r  <= bus.rsp_valid;
      ps_r  <= bus.rsp_valid && !bus.rsp_ready;
      pd_r  <= bus.rsp_data;
      pid_r <= bus.rsp_id;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      st_v[i] = 1'b0; st_op[i] = 3'd0; st_a[i] = 4'd0; st_b[i] = 4'd0; st_c[i] = 1'b0;
    end
    st_rr = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_op = 3'd0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
    bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
    bus.req1_cin = 1'b0;
    bus.rsp_ready = 1'b1;

    do_reset(2);

    // req0 add 3+4+0
    issue(0, 3'b001, 4'd3, 4'd4, 1'b0);
    repeat (6) tick();

    // req1 sub 9-5 under backpressure, with a one-cycle req0 pulse while busy
    st_rr = 1'b0;
    issue(1, 3'b010, 4'd9, 4'd5, 1'b1);
    repeat (2) tick();
    st_v[0] = 1'b1; st_op[0] = 3'b110; st_a[0] = 4'hA; st_b[0] = 4'hC; st_c[0] = 1'b0;
    tick();
    st_v[0] = 1'b0;
    repeat (4) tick();
    st_rr = 1'b1;
    repeat (3) tick();

    // both valid continuously: alternate grants starting with req0
    do_reset(2);
    st_op[0] = 3'b110; st_a[0] = 4'hA; st_b[0] = 4'hC; st_c[0] = 1'b0;
    st_op[1] = 3'b101; st_a[1] = 4'hF; st_b[1] = 4'h3; st_c[1] = 1'b0;
    st_v[0] = 1'b1; st_v[1] = 1'b1;
    repeat (22) tick();
    check_interval();
    st_v[0] = 1'b0; st_v[1] = 1'b0;
    repeat (6) tick();

    // req1 alone, back-to-back
    do_reset(2);
    issue(1, 3'b011, 4'h6, 4'h5, 1'b0);
    st_v[1] = 1'b1;
    repeat (16) tick();
    check_interval();
    st_v[1] = 1'b0;
    repeat (6) tick();

    // reset during EXEC, then a tie must go to req0
    do_reset(2);
    issue(0, 3'b001, 4'hF, 4'h1, 1'b1);
    do_reset(2);
    st_op[0] = 3'b100; st_a[0] = 4'h5; st_b[0] = 4'h2; st_c[0] = 1'b0;
    st_op[1] = 3'b000; st_a[1] = 4'h1; st_b[1] = 4'h9; st_c[1] = 1'b1;
    st_v[0] = 1'b1; st_v[1] = 1'b1;
    for (int k = 0; k < 5 && acc_id == -1; k++) tick();
    chk("tie_after_reset", acc_id, 0);
    st_v[0] = 1'b0; st_v[1] = 1'b0;
    repeat (6) tick();

    // randomized traffic with random backpressure and dropped requests
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (st_v[i] && (acc_id == i || $urandom_range(0, 9) == 0)) begin
          st_v[i] = 1'b0;
        end else if (!st_v[i] && $urandom_range(0, 2) == 0) begin
          st_v[i]  = 1'b1;
          st_op[i] = 3'($urandom_range(0, 7));
          st_a[i]  = 4'($urandom_range(0, 15));
          st_b[i]  = 4'($urandom_range(0, 15));
          st_c[i]  = 1'($urandom_range(0, 1));
        end
      end
      st_rr = ($urandom_range(0, 9) < 7);
      tick();
    end

    st_v[0] = 1'b0; st_v[1] = 1'b0; st_rr = 1'b1;
    for (int k = 0; k < 40 && sbq.size() != 0; k++) tick();
    chk("drain_empty", sbq.size(), 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
